// File: rtl/fe_pc_gen_pkg.sv
// ============================================================================
// Module  : fe_pc_gen_pkg
// Purpose : shared types for the fetch PC generator and its instruction FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

package fe_pc_gen_pkg;

  localparam int CPU_XLEN = 32;

  typedef logic [CPU_XLEN-1:0] cpu_t;

  localparam cpu_t RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fe_state_e;

  typedef struct packed {
    cpu_t pc;
    cpu_t ins;
  } fe_entry_t;

endpackage

`default_nettype wire

// File: rtl/fe_ins_fifo.sv
// ============================================================================
// Module  : fe_ins_fifo
// Purpose : circular instruction buffer with synchronous flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module fe_ins_fifo
  import fe_pc_gen_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fe_entry_t,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          valid,
  output logic [CW-1:0] count
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign valid   = (cnt != '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fe_pc_gen.sv
// ============================================================================
// Module  : fe_pc_gen
// Purpose : fetch PC generator, imem request FSM and redirect handling
// Revision: 1.0
// ============================================================================
`default_nettype none

module fe_pc_gen
  import fe_pc_gen_pkg::*;
#(
  parameter int             XLEN      = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int             BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_bj_en,
  input  logic [XLEN-1:0] bj_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            fe_valid,
  input  logic            fe_ready,
  output logic [XLEN-1:0] fe_pc,
  output logic [XLEN-1:0] fe_pc_add4,
  output logic [XLEN-1:0] fe_ins
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } entry_t;

  fe_state_e       state;
  fe_state_e       state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target_pc;

  logic            push;
  logic            pop;
  logic            flush;
  logic            buf_valid;
  logic [CW-1:0]   buf_count;
  entry_t          push_data;
  entry_t          head;

  logic            outstanding;
  logic [CW:0]     occupancy;
  logic [CW:0]     occ_after_push;

  logic            unused_bj_low;
  assign unused_bj_low = &{1'b1, bj_pc[1:0]};

  assign target_pc   = {bj_pc[XLEN-1:2], 2'b00};
  assign outstanding = (state == WAIT) || (state == DROP);
  assign occupancy   = {1'b0, buf_count} + (CW+1)'(outstanding);
  // A same-cycle pop frees a slot before the new word lands.
  assign occ_after_push = {1'b0, buf_count} + (CW+1)'(1) - (CW+1)'(pop);

  assign pop       = fe_ready && buf_valid;
  assign push_data = '{pc: req_pc, ins: imem_rdata};

  assign imem_req  = (state == REQ);
  assign imem_addr = {pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if ((state == REQ) && imem_gnt) begin
        req_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;

    case (state)
      IDLE: begin
        if (occupancy < (CW+1)'(BUF_DEPTH)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          pc_nxt    = pc + XLEN'(4);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = (occ_after_push < (CW+1)'(BUF_DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides the normal progression; a granted or still-pending
    // response belongs to the old stream and must be drained in DROP.
    if (ex_bj_en) begin
      flush  = 1'b1;
      push   = 1'b0;
      pc_nxt = target_pc;
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     state_nxt = imem_gnt    ? DROP : REQ;
        WAIT:    state_nxt = imem_rvalid ? REQ  : DROP;
        DROP:    state_nxt = imem_rvalid ? REQ  : DROP;
        default: state_nxt = REQ;
      endcase
    end
  end

  fe_ins_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (buf_valid),
    .count     (buf_count)
  );

  assign fe_valid   = buf_valid;
  assign fe_pc      = head.pc;
  assign fe_ins     = head.ins;
  assign fe_pc_add4 = head.pc + XLEN'(4);

endmodule

`default_nettype wire

// File: tb/tb_fe_pc_gen.sv
// ============================================================================
// Module  : tb_fe_pc_gen
// Purpose : directed self-checking bench for fe_pc_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fe_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_bj_en;
  logic [31:0] bj_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fe_valid;
  logic        fe_ready;
  logic [31:0] fe_pc;
  logic [31:0] fe_pc_add4;
  logic [31:0] fe_ins;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fe_pc_gen #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_bj_en    (ex_bj_en),
    .bj_pc       (bj_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fe_valid    (fe_valid),
    .fe_ready    (fe_ready),
    .fe_pc       (fe_pc),
    .fe_pc_add4  (fe_pc_add4),
    .fe_ins      (fe_ins)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expects REQ at exp_addr; grants it, returns data one cycle later.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_bj_en = 1'b0; bj_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; fe_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, fe_valid}, 32'd0);
    step();

    // Straight-line fetch, decode always ready.
    fe_ready = 1'b1;
    fetch_one("s1a", 32'h0, 32'h1111_0000);
    chk("s1a_valid", {31'd0, fe_valid}, 32'd1);
    chk("s1a_pc", fe_pc, 32'h0);
    chk("s1a_ins", fe_ins, 32'h1111_0000);
    chk("s1a_add4", fe_pc_add4, 32'h4);
    fetch_one("s1b", 32'h4, 32'h1111_0004);
    chk("s1b_pc", fe_pc, 32'h4);
    chk("s1b_ins", fe_ins, 32'h1111_0004);
    chk("s1b_add4", fe_pc_add4, 32'h8);
    fetch_one("s1c", 32'h8, 32'h1111_0008);
    chk("s1c_pc", fe_pc, 32'h8);
    chk("s1c_add4", fe_pc_add4, 32'hC);

    // Back-pressure: buffer fills, requests stop.
    rst = 1'b1; fe_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    fetch_one("s2a", 32'h0, 32'hAAAA_0000);
    fetch_one("s2b", 32'h4, 32'hAAAA_0004);
    chk("s2_full_req", {31'd0, imem_req}, 32'd0);
    chk("s2_full_pc", fe_pc, 32'h0);
    chk("s2_full_ins", fe_ins, 32'hAAAA_0000);
    step();
    step();
    chk("s2_hold_req", {31'd0, imem_req}, 32'd0);
    fe_ready = 1'b1;
    step();
    fe_ready = 1'b0;
    chk("s2_pop_pc", fe_pc, 32'h4);
    chk("s2_pop_ins", fe_ins, 32'hAAAA_0004);
    step();
    fetch_one("s2c", 32'h8, 32'hAAAA_0008);
    chk("s2_refull_req", {31'd0, imem_req}, 32'd0);

    // Redirect from IDLE.
    ex_bj_en = 1'b1; bj_pc = 32'h40;
    step();
    ex_bj_en = 1'b0;
    chk("idle_bj_req", {31'd0, imem_req}, 32'd1);
    chk("idle_bj_addr", imem_addr, 32'h40);
    chk("idle_bj_valid", {31'd0, fe_valid}, 32'd0);

    // Redirect in WAIT: buffered entry flushed, stale response dropped.
    fetch_one("s3a", 32'h40, 32'hBBBB_0040);
    chk("s3a_valid", {31'd0, fe_valid}, 32'd1);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    ex_bj_en = 1'b1; bj_pc = 32'h103;
    step();
    ex_bj_en = 1'b0;
    chk("s3_flush_valid", {31'd0, fe_valid}, 32'd0);
    chk("s3_drop_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("s3_drop_req2", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("s3_stale_valid", {31'd0, fe_valid}, 32'd0);
    fetch_one("s3b", 32'h100, 32'hBBBB_0100);
    chk("s3b_valid", {31'd0, fe_valid}, 32'd1);
    chk("s3b_pc", fe_pc, 32'h100);
    chk("s3b_ins", fe_ins, 32'hBBBB_0100);

    // Redirect in REQ without gnt, then redirect coinciding with rvalid.
    ex_bj_en = 1'b1; bj_pc = 32'h20;
    step();
    ex_bj_en = 1'b0;
    chk("s4_addr20", imem_addr, 32'h20);
    chk("s4_flush_valid", {31'd0, fe_valid}, 32'd0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0020;
    ex_bj_en = 1'b1; bj_pc = 32'h200;
    step();
    imem_rvalid = 1'b0; ex_bj_en = 1'b0;
    chk("s4_nopush_valid", {31'd0, fe_valid}, 32'd0);
    fetch_one("s4b", 32'h200, 32'hCCCC_0200);
    chk("s4b_pc", fe_pc, 32'h200);
    chk("s4b_ins", fe_ins, 32'hCCCC_0200);

    // Redirect in REQ with gnt held off for three cycles.
    ex_bj_en = 1'b1; bj_pc = 32'h300;
    step();
    ex_bj_en = 1'b0;
    chk("s5_req0", {31'd0, imem_req}, 32'd1);
    chk("s5_addr0", imem_addr, 32'h300);
    step();
    chk("s5_req1", {31'd0, imem_req}, 32'd1);
    chk("s5_addr1", imem_addr, 32'h300);
    step();
    fetch_one("s5g", 32'h300, 32'hDDDD_0300);
    chk("s5_pc", fe_pc, 32'h300);
    chk("s5_ins", fe_ins, 32'hDDDD_0300);

    // Reset while WAIT, response arrives in first post-reset cycle.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    chk("s6_idle_req", {31'd0, imem_req}, 32'd0);
    chk("s6_idle_valid", {31'd0, fe_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    chk("s6_req", {31'd0, imem_req}, 32'd1);
    chk("s6_addr", imem_addr, 32'h0);
    chk("s6_valid", {31'd0, fe_valid}, 32'd0);

    // PC wrap at the top of the address space.
    ex_bj_en = 1'b1; bj_pc = 32'hFFFF_FFFC;
    step();
    ex_bj_en = 1'b0;
    fe_ready = 1'b1;
    fetch_one("s7", 32'hFFFF_FFFC, 32'hEEEE_FFFC);
    chk("s7_pc", fe_pc, 32'hFFFF_FFFC);
    chk("s7_add4", fe_pc_add4, 32'h0);
    chk("s7_ins", fe_ins, 32'hEEEE_FFFC);
    chk("s7_wrap_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
